// File: rtl/alu_pkg.sv
// Operation encoding and payload helpers shared by the ALU pipeline files.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SLL  = 3'b101,
    OP_SRL  = 3'b110,
    OP_PASS = 3'b111
  } alu_op_e;

  // Payload carried through every stage: {result, zero, carry}.
  localparam int FLAG_BITS = 2;

endpackage

// File: rtl/alu_pipe_stage.sv
// One valid/ready register slice; loads when empty or when its content leaves this cycle.
module alu_pipe_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_r;
  logic [WIDTH-1:0] data_r;

  assign in_ready  = (~valid_r) | out_ready;
  assign out_valid = valid_r;
  assign out_data  = data_r;

  // Slice register: payload only updates on an accepted beat so held data stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      data_r  <= '0;
    end else if (in_ready) begin
      valid_r <= in_valid;
      if (in_valid) begin
        data_r <= in_data;
      end else begin
        data_r <= data_r;
      end
    end else begin
      valid_r <= valid_r;
      data_r  <= data_r;
    end
  end

endmodule

// File: rtl/types.svh
// Shared fixed-width scalar types for fixed 32-bit datapaths elsewhere in the codebase.
`ifndef TYPES_SVH
`define TYPES_SVH
typedef logic [31:0] word_t;
typedef logic [7:0]  byte_t;
`endif

// File: rtl/alu_pipe.sv
// Pipelined ALU: combinational compute, STAGES register slices, output handshake counter.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [2:0]            in_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_zero,
  output logic                  out_carry,
  input  logic                  clear_count,
  output logic [CNT_WIDTH-1:0]  txn_count
);

  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int PW  = DATA_WIDTH + FLAG_BITS;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [DATA_WIDTH:0]   sum_s;
  logic [DATA_WIDTH:0]   diff_s;
  logic [SHW-1:0]        shamt_s;
  logic [DATA_WIDTH-1:0] result_s;
  logic                  carry_s;
  logic                  zero_s;
  logic [PW-1:0]         pay_s;
  logic [CNT_WIDTH-1:0]  cnt_r;

  // Operation decode; the extra MSB of the SUB difference is the unsigned borrow.
  always_comb begin
    sum_s    = {1'b0, in_a} + {1'b0, in_b};
    diff_s   = {1'b0, in_a} - {1'b0, in_b};
    shamt_s  = in_b[SHW-1:0];
    result_s = '0;
    carry_s  = 1'b0;
    case (alu_op_e'(in_op))
      OP_ADD: begin
        result_s = sum_s[DATA_WIDTH-1:0];
        carry_s  = sum_s[DATA_WIDTH];
      end
      OP_SUB: begin
        result_s = diff_s[DATA_WIDTH-1:0];
        carry_s  = diff_s[DATA_WIDTH];
      end
      OP_AND:  result_s = in_a & in_b;
      OP_OR:   result_s = in_a | in_b;
      OP_XOR:  result_s = in_a ^ in_b;
      OP_SLL:  result_s = in_a << shamt_s;
      OP_SRL:  result_s = in_a >> shamt_s;
      OP_PASS: result_s = in_b;
      default: begin
        result_s = '0;
        carry_s  = 1'b0;
      end
    endcase
    zero_s = (result_s == '0);
    pay_s  = {result_s, zero_s, carry_s};
  end

  // Each stage lives in its own generate scope so the ready chain has distinct nets per stage.
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic          up_valid;
    logic [PW-1:0] up_data;
    logic          dn_ready;
    logic          rdy;
    logic          vld;
    logic [PW-1:0] dat;

    if (g == 0) begin : g_first
      assign up_valid = in_valid;
      assign up_data  = pay_s;
    end else begin : g_mid
      assign up_valid = g_stage[g-1].vld;
      assign up_data  = g_stage[g-1].dat;
    end

    if (g == STAGES - 1) begin : g_last
      assign dn_ready = out_ready;
    end else begin : g_inner
      assign dn_ready = g_stage[g+1].rdy;
    end

    alu_pipe_stage #(
      .WIDTH(PW)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (up_valid),
      .in_ready (rdy),
      .in_data  (up_data),
      .out_valid(vld),
      .out_ready(dn_ready),
      .out_data (dat)
    );
  end

  assign in_ready   = rst_n & g_stage[0].rdy;
  assign out_valid  = g_stage[STAGES-1].vld;
  assign out_result = g_stage[STAGES-1].dat[PW-1:FLAG_BITS];
  assign out_zero   = g_stage[STAGES-1].dat[1];
  assign out_carry  = g_stage[STAGES-1].dat[0];
  assign txn_count  = cnt_r;

  // Completed-handshake counter; clear wins over a coincident handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clear_count) begin
      cnt_r <= '0;
    end else if (out_valid && out_ready) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule
